// File: rtl/pattern_mode_ctrl_pkg.sv
// Shared constants and types for the test-pattern mode controller.
// Timing constants match the ones used by the timing generator and the debouncer.
package pattern_mode_ctrl_pkg;

  localparam int unsigned TIMING_H_TOTAL = 1344;
  localparam int unsigned TIMING_V_TOTAL = 806;

  localparam int unsigned PAT_W   = 4;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned BLANK_W = 4;

  typedef enum logic {
    StManual = 1'b0,
    StAuto   = 1'b1
  } mode_state_e;

  function automatic logic [PAT_W-1:0] wrap_inc(logic [PAT_W-1:0] p, int unsigned n);
    return (p == PAT_W'(n - 1)) ? '0 : p + PAT_W'(1);
  endfunction

  function automatic logic [PAT_W-1:0] wrap_dec(logic [PAT_W-1:0] p, int unsigned n);
    return (p == '0) ? PAT_W'(n - 1) : p - PAT_W'(1);
  endfunction

endpackage

// File: rtl/pattern_mode_ctrl_if.sv
// Timing-counter, button and pattern-status bundle of the mode controller.
// master drives counters and buttons; slave is the controller.
interface pattern_mode_ctrl_if;
  import pattern_mode_ctrl_pkg::*;

  logic [15:0]      Pixel_Cnt;
  logic [15:0]      Line_Cnt;
  logic             Btn_Next;
  logic             Btn_Prev;
  logic             Btn_Mode;
  logic [PAT_W-1:0] Pattern_Sel;
  logic             Auto_Mode;
  logic             Blank_En;
  logic             Frame_Tick;

  modport master (
    output Pixel_Cnt, Line_Cnt, Btn_Next, Btn_Prev, Btn_Mode,
    input  Pattern_Sel, Auto_Mode, Blank_En, Frame_Tick
  );

  modport slave (
    input  Pixel_Cnt, Line_Cnt, Btn_Next, Btn_Prev, Btn_Mode,
    output Pattern_Sel, Auto_Mode, Blank_En, Frame_Tick
  );

endinterface

// File: rtl/pattern_wrap_step.sv
// Registered modulo-N_PATTERN up/down stepper holding the committed pattern index.
// inc and dec together cancel; load_zero has priority over both.
module pattern_wrap_step
  import pattern_mode_ctrl_pkg::*;
#(
  parameter int unsigned N_PATTERN = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load_zero,
  output logic [PAT_W-1:0] pattern_sel
);

  logic [PAT_W-1:0] pattern_d, pattern_q;

  always_comb begin
    pattern_d = pattern_q;
    if (load_zero) begin
      pattern_d = '0;
    end else if (inc && !dec) begin
      pattern_d = wrap_inc(pattern_q, N_PATTERN);
    end else if (dec && !inc) begin
      pattern_d = wrap_dec(pattern_q, N_PATTERN);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern_sel = pattern_q;

endmodule

// File: rtl/pattern_mode_ctrl.sv
// Frame-synchronous test-pattern sequencer: captures button requests, commits them at
// the frame-end pixel, auto-advances in AUTO mode and blanks after every change.
module pattern_mode_ctrl
  import pattern_mode_ctrl_pkg::*;
#(
  parameter int unsigned H_TOTAL      = TIMING_H_TOTAL,
  parameter int unsigned V_TOTAL      = TIMING_V_TOTAL,
  parameter int unsigned N_PATTERN    = 8,
  parameter int unsigned DWELL_FRAMES = 120,
  parameter int unsigned BLANK_FRAMES = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  pattern_mode_ctrl_if.slave bus
);

  logic fe;
  assign fe = (bus.Pixel_Cnt == 16'(H_TOTAL - 1)) && (bus.Line_Cnt == 16'(V_TOTAL - 1));

  // Pending requests: a pulse on the fe cycle itself survives the clear.
  logic pend_next_d, pend_next_q;
  logic pend_prev_d, pend_prev_q;
  logic pend_mode_d, pend_mode_q;

  assign pend_next_d = bus.Btn_Next | (pend_next_q & ~fe);
  assign pend_prev_d = bus.Btn_Prev | (pend_prev_q & ~fe);
  assign pend_mode_d = bus.Btn_Mode | (pend_mode_q & ~fe);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_next_q <= 1'b0;
      pend_prev_q <= 1'b0;
      pend_mode_q <= 1'b0;
    end else begin
      pend_next_q <= pend_next_d;
      pend_prev_q <= pend_prev_d;
      pend_mode_q <= pend_mode_d;
    end
  end

  // Mode FSM.
  mode_state_e state_d, state_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StManual;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fe && pend_mode_q) begin
      state_d = (state_q == StManual) ? StAuto : StManual;
    end
  end

  // Step arbitration and dwell counting at commit.
  logic               step_next, step_prev, manual_step, auto_step;
  logic               pat_inc, pat_dec, pat_change;
  logic [DWELL_W-1:0] dwell_d, dwell_q;

  assign step_next   = fe & pend_next_q & ~pend_prev_q;
  assign step_prev   = fe & pend_prev_q & ~pend_next_q;
  assign manual_step = step_next | step_prev;

  always_comb begin
    dwell_d   = dwell_q;
    auto_step = 1'b0;
    if (fe) begin
      if (pend_mode_q || manual_step) begin
        dwell_d = '0;
      end else if (state_q == StAuto) begin
        if (dwell_q == DWELL_W'(DWELL_FRAMES - 1)) begin
          dwell_d   = '0;
          auto_step = 1'b1;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign pat_inc    = step_next | auto_step;
  assign pat_dec    = step_prev;
  assign pat_change = pat_inc | pat_dec;

  logic [PAT_W-1:0] pattern_sel;

  pattern_wrap_step #(
    .N_PATTERN (N_PATTERN)
  ) u_step (
    .Clock       (Clock),
    .Reset       (Reset),
    .inc         (pat_inc),
    .dec         (pat_dec),
    .load_zero   (1'b0),
    .pattern_sel (pattern_sel)
  );

  // Blank counter: Blank_En tracks a non-zero count, so it drops the cycle after the
  // fe that brings the count to zero.
  logic [BLANK_W-1:0] blank_d, blank_q;

  always_comb begin
    blank_d = blank_q;
    if (fe) begin
      if (pat_change) begin
        blank_d = BLANK_W'(BLANK_FRAMES);
      end else if (blank_q != '0) begin
        blank_d = blank_q - BLANK_W'(1);
      end
    end
  end

  logic tick_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      blank_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      blank_q <= blank_d;
      tick_q  <= fe;
    end
  end

  always_comb begin
    bus.Pattern_Sel = pattern_sel;
    bus.Auto_Mode   = (state_q == StAuto);
    bus.Blank_En    = (blank_q != '0);
    bus.Frame_Tick  = tick_q;
  end

endmodule

// File: tb/tb_pattern_mode_ctrl.sv
// Directed bench for pattern_mode_ctrl on a 32-cycle frame with a cycle scoreboard.
module tb_pattern_mode_ctrl;
  import pattern_mode_ctrl_pkg::*;

  localparam int unsigned HT = 8;
  localparam int unsigned VT = 4;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 3;
  localparam int unsigned BF = 2;
  localparam int unsigned FL = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_mode_ctrl_if bus ();

  pattern_mode_ctrl #(
    .H_TOTAL      (HT),
    .V_TOTAL      (VT),
    .N_PATTERN    (NP),
    .DWELL_FRAMES (DW),
    .BLANK_FRAMES (BF)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] pat;
    logic       auto_m;
    logic       blank;
    logic       tick;
  } obs_t;

  obs_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned pos = 0;

  int          m_pat;
  int unsigned m_dwell;
  int unsigned m_blank;
  bit          m_auto, m_pn, m_pp, m_pm;

  function automatic obs_t dut_obs();
    return {bus.Pattern_Sel, bus.Auto_Mode, bus.Blank_En, bus.Frame_Tick};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pat = 0; m_dwell = 0; m_blank = 0;
    m_auto = 0; m_pn = 0; m_pp = 0; m_pm = 0;
  endtask

  // Expected outputs after the edge at which the current inputs are sampled.
  task automatic model_step(input bit bn, input bit bp, input bit bm);
    bit   fe, ns, ps, adv;
    obs_t e;
    fe = (pos == FL - 1);
    if (fe) begin
      ns  = m_pn && !m_pp;
      ps  = m_pp && !m_pn;
      adv = 0;
      if (m_pm) begin
        m_auto  = !m_auto;
        m_dwell = 0;
      end else if (ns || ps) begin
        m_dwell = 0;
      end else if (m_auto) begin
        if (m_dwell == DW - 1) begin
          adv     = 1;
          m_dwell = 0;
        end else begin
          m_dwell++;
        end
      end
      if (ns || adv) begin
        m_pat   = (m_pat + 1) % NP;
        m_blank = BF;
      end else if (ps) begin
        m_pat   = (m_pat + NP - 1) % NP;
        m_blank = BF;
      end else if (m_blank > 0) begin
        m_blank--;
      end
      m_pn = bn; m_pp = bp; m_pm = bm;
    end else begin
      m_pn = m_pn | bn; m_pp = m_pp | bp; m_pm = m_pm | bm;
    end
    e.pat    = 4'(m_pat);
    e.auto_m = m_auto;
    e.blank  = (m_blank != 0);
    e.tick   = fe;
    exp_q.push_back(e);
  endtask

  task automatic adv_cnt();
    pos           = (pos + 1) % FL;
    bus.Pixel_Cnt = 16'(pos % HT);
    bus.Line_Cnt  = 16'(pos / HT);
  endtask

  task automatic cyc(input bit bn, input bit bp, input bit bm);
    obs_t e;
    bus.Btn_Next = bn;
    bus.Btn_Prev = bp;
    bus.Btn_Mode = bm;
    model_step(bn, bp, bm);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cycle", 32'(dut_obs()), 32'(e));
    bus.Btn_Next = 1'b0;
    bus.Btn_Prev = 1'b0;
    bus.Btn_Mode = 1'b0;
    adv_cnt();
  endtask

  task automatic goto_pos(input int unsigned p);
    while (pos != p) cyc(0, 0, 0);
  endtask

  // Runs through the next frame-end cycle; outputs then show the commit.
  task automatic fe_cycle();
    goto_pos(FL - 1);
    cyc(0, 0, 0);
  endtask

  task automatic press(input bit bn, input bit bp, input bit bm, input int unsigned at);
    goto_pos(at);
    cyc(bn, bp, bm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks;
    int blank_hi;

    bus.Pixel_Cnt = '0;
    bus.Line_Cnt  = '0;
    bus.Btn_Next  = 1'b0;
    bus.Btn_Prev  = 1'b0;
    bus.Btn_Mode  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_obs()), 32'd0);
    rst_n = 1'b1;

    // Idle frames.
    ticks = 0;
    repeat (96) begin
      cyc(0, 0, 0);
      if (bus.Frame_Tick) ticks++;
    end
    check("idle_ticks", 32'(ticks), 32'd3);
    check("idle_pat", 32'(bus.Pattern_Sel), 32'd0);
    check("idle_auto", 32'(bus.Auto_Mode), 32'd0);

    // Manual steps, wrap and blank window length.
    press(1, 0, 0, 10);
    fe_cycle();
    check("next_0_to_1", 32'(bus.Pattern_Sel), 32'd1);
    blank_hi = bus.Blank_En ? 1 : 0;
    repeat (64) begin
      cyc(0, 0, 0);
      if (bus.Blank_En) blank_hi++;
    end
    check("blank_len", 32'(blank_hi), 32'd64);
    check("blank_off", 32'(bus.Blank_En), 32'd0);

    press(0, 1, 0, 10);
    fe_cycle();
    check("prev_1_to_0", 32'(bus.Pattern_Sel), 32'd0);
    press(0, 1, 0, 10);
    fe_cycle();
    check("prev_wrap", 32'(bus.Pattern_Sel), 32'd3);
    press(1, 0, 0, 10);
    fe_cycle();
    check("next_wrap", 32'(bus.Pattern_Sel), 32'd0);

    // Pulse on the fe cycle commits one frame later.
    goto_pos(FL - 1);
    cyc(1, 0, 0);
    check("on_fe_hold", 32'(bus.Pattern_Sel), 32'd0);
    fe_cycle();
    check("on_fe_late", 32'(bus.Pattern_Sel), 32'd1);
    fe_cycle();
    fe_cycle();
    check("blank_expired", 32'(bus.Blank_En), 32'd0);

    // Next and prev in one frame cancel.
    press(1, 0, 0, 5);
    press(0, 1, 0, 20);
    fe_cycle();
    check("both_pat", 32'(bus.Pattern_Sel), 32'd1);
    check("both_blank", 32'(bus.Blank_En), 32'd0);

    // Auto mode.
    press(0, 0, 1, 3);
    fe_cycle();
    check("auto_enter", 32'(bus.Auto_Mode), 32'd1);
    check("auto_enter_pat", 32'(bus.Pattern_Sel), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      fe_cycle();
      check("auto_adv", 32'(bus.Pattern_Sel), 32'((1 + k / 3) % NP));
    end

    // Manual step at dwell count 1 restarts the dwell.
    fe_cycle();
    press(1, 0, 0, 8);
    fe_cycle();
    check("auto_manual", 32'(bus.Pattern_Sel), 32'd1);
    fe_cycle();
    fe_cycle();
    check("dwell_restart", 32'(bus.Pattern_Sel), 32'd1);
    fe_cycle();
    check("auto_after_manual", 32'(bus.Pattern_Sel), 32'd2);
    check("auto_blank", 32'(bus.Blank_En), 32'd1);

    // Asynchronous reset mid-blank with a request pending.
    press(1, 0, 0, 5);
    goto_pos(12);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_obs()), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      adv_cnt();
    end
    rst_n = 1'b1;
    model_reset();
    fe_cycle();
    check("post_reset_pat", 32'(bus.Pattern_Sel), 32'd0);
    check("post_reset_auto", 32'(bus.Auto_Mode), 32'd0);

    // Leaving auto mode stops advancing.
    press(0, 0, 1, 4);
    fe_cycle();
    check("auto_reenter", 32'(bus.Auto_Mode), 32'd1);
    press(0, 0, 1, 4);
    fe_cycle();
    check("auto_exit", 32'(bus.Auto_Mode), 32'd0);
    repeat (4) fe_cycle();
    check("manual_stopped", 32'(bus.Pattern_Sel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pattern_mode_ctrl.md
Name: pattern_mode_ctrl

Overview:
Frame-synchronous controller that sequences the test-pattern selection for the RGB output path from debounced button pulses. It accepts next, previous and auto-toggle requests, arbitrates them, and commits a change only at the frame-end pixel. In auto mode it advances the pattern every DWELL_FRAMES frames. It holds a blanking window after each pattern change so the datapath never shows a torn or partial transition frame.

Parameters:
H_TOTAL, 1344, total pixels per line; must match the shared timing constants.
V_TOTAL, 806, total lines per frame; must match the shared timing constants.
N_PATTERN, 8, number of selectable patterns; legal range 2..16.
DWELL_FRAMES, 120, frames per pattern in auto mode; legal range 1..65535.
BLANK_FRAMES, 2, frames of Blank_En after each change; legal range 0..15, where 0 disables blanking.

Ports:
Clock  in  1  system/pixel clock, rising edge
Reset  in  1  asynchronous active-low reset
Pixel_Cnt  in  16  horizontal counter from the timing generator
Line_Cnt  in  16  vertical counter from the timing generator
Btn_Next  in  1  single-cycle debounced pulse: advance pattern
Btn_Prev  in  1  single-cycle debounced pulse: step pattern back
Btn_Mode  in  1  single-cycle debounced pulse: toggle manual/auto
Pattern_Sel  out  4  committed pattern index
Auto_Mode  out  1  high while the FSM is in AUTO
Blank_En  out  1  high during the post-change blanking window
Frame_Tick  out  1  one-cycle pulse, registered, the cycle after frame end

Behaviour:
- fe (internal, combinational) = (Pixel_Cnt == H_TOTAL-1) && (Line_Cnt == V_TOTAL-1).
- Reset values (async, active-low): Pattern_Sel=0, Auto_Mode=0, Blank_En=0, Frame_Tick=0. Pending flags, dwell counter and blank counter are all 0. State is MANUAL.
- Reset mid-operation aborts everything immediately; there is no deferred commit.
- Pending capture:
  - A pulse on Btn_Next, Btn_Prev or Btn_Mode sets pend_next, pend_prev or pend_mode respectively.
  - Pending flags clear on an fe cycle.
  - A pulse arriving on the fe cycle itself is not consumed. It remains pending, set wins over clear, and it commits at the next fe.
  - Repeated pulses within one frame collapse to a single request.
- Commit happens on fe cycles only. Results appear in outputs on the following cycle. Latency from a pulse (not on fe) to Pattern_Sel is the next fe plus 1 cycle.
- FSM states: MANUAL, AUTO. Transitions happen only at fe with pend_mode=1: MANUAL->AUTO or AUTO->MANUAL. Any state change clears the dwell counter.
- Step arbitration at commit (both states):
  - pend_next & pend_prev together: no step; both are discarded.
  - next only: Pattern_Sel = (P==N_PATTERN-1) ? 0 : P+1.
  - prev only: Pattern_Sel = (P==0) ? N_PATTERN-1 : P-1.
  - A manual step in AUTO clears the dwell counter.
- Auto advance:
  - In AUTO with no manual step, each fe increments the dwell counter (16 bits).
  - When the counter equals DWELL_FRAMES-1 at fe, the pattern steps "next" and the counter returns to 0.
  - No auto advance occurs on the fe where AUTO is entered.
  - pend_mode together with a manual step: both apply in the same commit.
- Blanking:
  - Any commit that changes Pattern_Sel loads the blank counter with BLANK_FRAMES and sets Blank_En (if BLANK_FRAMES > 0).
  - Each later fe decrements the counter. Blank_En falls the cycle after the fe at which the counter reaches 0, giving exactly BLANK_FRAMES full frames.
  - A change during blanking reloads the counter.
  - A step that yields the same index is impossible, since N_PATTERN ≥ 2.
- Frame_Tick = fe registered. It is high for 1 cycle, coincident with the updated outputs.

Decomposition:
- Shared package/include:
  - H_TOTAL/V_TOTAL timing constants, already shared by the timing generator and the debouncer.
  - State encodings MANUAL=1'b0, AUTO=1'b1.
  - Pattern index width (4).
- One natural sub-module, pattern_wrap_step: combinational+registered modulo-N_PATTERN up/down stepper holding Pattern_Sel, with inc, dec and load-zero controls.
- Frame detection, pending flags, FSM and counters stay in the top level.

Test Plan:
Bench settings: H_TOTAL=8, V_TOTAL=4 (32-cycle frame), N_PATTERN=4, DWELL_FRAMES=3, BLANK_FRAMES=2.
- Reset, then release and run 3 frames with no buttons -> Pattern_Sel=0, Auto_Mode=0, Blank_En=0, Frame_Tick high once per 32 cycles.
- Btn_Next pulse at mid-frame -> Pattern_Sel 0->1 the cycle after the next fe; Blank_En high for exactly 2 frames (64 cycles). Btn_Prev at Pattern_Sel=0 -> 3 (wrap). Btn_Next at 3 -> 0.
- Btn_Next pulse exactly on the fe cycle -> no change at that fe; Pattern_Sel increments at the following fe (32 cycles later). Btn_Next and Btn_Prev in the same frame -> Pattern_Sel unchanged, Blank_En stays 0.
- Btn_Mode pulse -> Auto_Mode=1 after fe. Pattern_Sel then advances 0->1->2->3->0 every 3 frames, first step 3 frames after entry. Btn_Mode again -> Auto_Mode=0 and advancing stops.
- In AUTO, Btn_Next at dwell count 1 -> immediate step at fe and dwell restarts. The next auto step comes 3 frames later, not 1.
- Assert Reset mid-blank in AUTO at Pattern_Sel=2 -> all outputs 0 asynchronously. After release the block is in MANUAL with Pattern_Sel=0, and no stale pending request commits.
